// File: rtl/myo_spi_scheduler.sv
// myo_spi_scheduler: shares one SPI master across the motor slots of a
// myocontrol instance. It polls the masked motors once per update period in
// ascending order and interleaves one-shot host frames ahead of the next
// polled slot. It owns the slave-select vector and the start/done handshake.
module myo_spi_scheduler #(
  parameter int NUMBER_OF_MOTORS = 6,
  parameter int SETUP_CYCLES     = 4,
  parameter int HOLD_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int PERIOD_WIDTH     = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [PERIOD_WIDTH-1:0]     update_period,
  input  logic [NUMBER_OF_MOTORS-1:0] motor_mask,
  input  logic                        power_sense_n,
  input  logic                        host_req,
  input  logic [7:0]                  host_motor,
  output logic                        host_ack,
  output logic                        spi_start,
  input  logic                        spi_done,
  output logic [NUMBER_OF_MOTORS-1:0] ss_n,
  output logic [7:0]                  motor_index,
  output logic                        is_host_slot,
  output logic                        frame_done,
  output logic                        round_done,
  output logic                        timeout_err,
  output logic                        overrun,
  input  logic                        clear_errors
);

  localparam int CNT_MAX =
    (TIMEOUT_CYCLES > SETUP_CYCLES)
      ? ((TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES)
      : ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]        SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]        HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]        TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]              MOTORS     = 8'(NUMBER_OF_MOTORS);
  localparam logic [PERIOD_WIDTH-1:0] PER_ONE    = PERIOD_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, SELECT, START, WAIT, HOLD, RELEASE
  } state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [PERIOD_WIDTH-1:0]     per_cnt;
  logic                        tick;
  logic                        round_active;
  logic [NUMBER_OF_MOTORS-1:0] round_mask;
  logic [7:0]                  ptr;
  logic [8:0]                  first_hit;
  logic [8:0]                  next_hit;
  logic                        wait_to;
  logic                        hold_end;
  logic                        finish;

  // Lowest set mask bit at or above 'from'; bit 8 flags that one was found.
  function automatic logic [8:0] find_set(input logic [NUMBER_OF_MOTORS-1:0] m,
                                          input logic [7:0] from);
    logic [8:0] r;
    r = '0;
    for (int i = NUMBER_OF_MOTORS - 1; i >= 0; i--) begin
      if (m[i] && (8'(i) >= from)) r = {1'b1, 8'(i)};
    end
    return r;
  endfunction

  // Active-low select vector with only slot 'idx' driven low.
  function automatic logic [NUMBER_OF_MOTORS-1:0] sel_vec(input logic [7:0] idx);
    logic [NUMBER_OF_MOTORS-1:0] v;
    for (int i = 0; i < NUMBER_OF_MOTORS; i++) v[i] = (idx != 8'(i));
    return v;
  endfunction

  // Wrap detect: periods of 0 or 1 tick every enabled cycle.
  always_comb begin
    tick      = enable && ((update_period <= PER_ONE) ||
                           (per_cnt >= update_period - PER_ONE));
    first_hit = find_set(motor_mask, 8'd0);
    next_hit  = find_set(round_mask, ptr + 8'd1);
    wait_to   = (state == WAIT) && !spi_done && (cnt >= TO_LAST);
    hold_end  = (state == HOLD) && (cnt == HOLD_LAST);
    finish    = wait_to || hold_end;
  end

  // Period counter: free-runs while enabled, parked at zero otherwise.
  always_ff @(posedge clock) begin
    if (reset || !enable || tick) per_cnt <= '0;
    else                          per_cnt <= per_cnt + PER_ONE;
  end

  // Round bookkeeping: start on tick, advance pointer as polled slots finish.
  always_ff @(posedge clock) begin
    if (reset) begin
      round_active <= 1'b0;
      round_mask   <= '0;
      ptr          <= '0;
      round_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (clear_errors) overrun <= 1'b0;
      // A timed-out polled slot still counts as visited.
      if (finish && !is_host_slot && round_active) begin
        if (next_hit[8]) begin
          ptr <= next_hit[7:0];
        end else begin
          ptr          <= '0;
          round_active <= 1'b0;
          round_done   <= 1'b1;
        end
      end
      if (tick) begin
        if (round_active) begin
          overrun <= 1'b1;
        end else if (!first_hit[8]) begin
          round_done <= 1'b1;
        end else begin
          round_active <= 1'b1;
          round_mask   <= motor_mask;
          ptr          <= first_hit[7:0];
        end
      end
      // Losing enable abandons the remainder of the round silently.
      if (!enable) begin
        round_active <= 1'b0;
        ptr          <= '0;
      end
    end
  end

  // Frame sequencer with registered select, handshake and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ss_n         <= '1;
      spi_start    <= 1'b0;
      host_ack     <= 1'b0;
      frame_done   <= 1'b0;
      motor_index  <= '0;
      is_host_slot <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      spi_start  <= 1'b0;
      host_ack   <= 1'b0;
      frame_done <= 1'b0;
      if (clear_errors) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!power_sense_n) begin
            if (host_req) begin
              // Out-of-range targets are acknowledged without touching the bus.
              if (host_motor >= MOTORS) begin
                host_ack <= 1'b1;
              end else begin
                motor_index  <= host_motor;
                is_host_slot <= 1'b1;
                ss_n         <= sel_vec(host_motor);
                cnt          <= '0;
                state        <= SELECT;
              end
            end else if (round_active) begin
              motor_index  <= ptr;
              is_host_slot <= 1'b0;
              ss_n         <= sel_vec(ptr);
              cnt          <= '0;
              state        <= SELECT;
            end
          end
        end
        SELECT: begin
          if (cnt == SETUP_LAST) begin
            cnt       <= '0;
            spi_start <= 1'b1;
            state     <= START;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        START: begin
          // Count runs in cycles since spi_start was high.
          cnt   <= CNT_ONE;
          state <= WAIT;
        end
        WAIT: begin
          if (spi_done) begin
            cnt   <= '0;
            state <= HOLD;
          end else if (wait_to) begin
            timeout_err <= 1'b1;
            ss_n        <= '1;
            state       <= RELEASE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (hold_end) begin
            ss_n <= '1;
            if (is_host_slot) host_ack   <= 1'b1;
            else              frame_done <= 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RELEASE: begin
          is_host_slot <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Directed bench for myo_spi_scheduler: polling order and timing, host
// priority, timeout, overrun, reset mid-frame and the host/power edge cases.
module tb_myo_spi_scheduler;

  localparam int N = 6;
  localparam logic [N-1:0] ALL1 = '1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [31:0]  update_period;
  logic [N-1:0] motor_mask;
  logic         power_sense_n;
  logic         host_req;
  logic [7:0]   host_motor;
  logic         host_ack;
  logic         spi_start;
  logic         spi_done;
  logic [N-1:0] ss_n;
  logic [7:0]   motor_index;
  logic         is_host_slot;
  logic         frame_done;
  logic         round_done;
  logic         timeout_err;
  logic         overrun;
  logic         clear_errors;

  int checks = 0;
  int errors = 0;

  // SPI master model: spi_done 'done_delay' cycles after spi_start (0 = never)
  int done_delay = 0;
  int spi_cnt    = 0;

  // Monitor state
  int n_fd = 0, n_start = 0, n_hack = 0, onehot_bad = 0;
  int log_idx[$];
  int log_host[$];
  int low_len[$];
  int gap_len[$];
  int low_run = 0, high_run = 0;
  bit prev_low = 1'b0;

  longint last_hit_time;

  myo_spi_scheduler #(
    .NUMBER_OF_MOTORS(N), .SETUP_CYCLES(4), .HOLD_CYCLES(4),
    .TIMEOUT_CYCLES(1024), .PERIOD_WIDTH(32)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable), .update_period(update_period),
    .motor_mask(motor_mask), .power_sense_n(power_sense_n), .host_req(host_req),
    .host_motor(host_motor), .host_ack(host_ack), .spi_start(spi_start),
    .spi_done(spi_done), .ss_n(ss_n), .motor_index(motor_index),
    .is_host_slot(is_host_slot), .frame_done(frame_done), .round_done(round_done),
    .timeout_err(timeout_err), .overrun(overrun), .clear_errors(clear_errors)
  );

  initial forever #5 clk = ~clk;

  // SPI master responder, driven on the falling edge
  initial begin
    spi_done = 1'b0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (spi_start) begin
        spi_cnt = done_delay;
      end else if (spi_cnt > 0) begin
        spi_cnt = spi_cnt - 1;
        if (spi_cnt == 0) spi_done = 1'b1;
      end
    end
  end

  // Bus monitor, sampled just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    n_fd    += int'(frame_done);
    n_start += int'(spi_start);
    n_hack  += int'(host_ack);
    if ($countones(~ss_n) > 1) onehot_bad++;
    if (ss_n != ALL1) begin
      if (!prev_low) begin
        log_idx.push_back(int'(motor_index));
        log_host.push_back(int'(is_host_slot));
        gap_len.push_back(high_run);
        low_run = 1;
      end else begin
        low_run++;
      end
      prev_low = 1'b1;
    end else begin
      if (prev_low) begin
        low_len.push_back(low_run);
        high_run = 1;
      end else begin
        high_run++;
      end
      prev_low = 1'b0;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // what: 0 any ss_n low, 1 spi_start, 2 host_ack, 3 timeout_err, 4 round_done
  task automatic wait_for(input int what, input int budget, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (what)
        0:       hit = (ss_n != ALL1);
        1:       hit = spi_start;
        2:       hit = host_ack;
        3:       hit = timeout_err;
        default: hit = round_done;
      endcase
    end
    last_hit_time = $time;
    check(tag, longint'(hit), 1);
  endtask

  initial begin
    int b, lb, gb, fd0, st0, ha0;
    longint t1, t2;
    int exp_i[7];
    int exp_h[7];
    exp_i = '{0, 3, 1, 2, 3, 4, 5};
    exp_h = '{0, 1, 0, 0, 0, 0, 0};

    reset = 1'b1; enable = 1'b0; update_period = 32'd2000; motor_mask = '0;
    power_sense_n = 1'b0; host_req = 1'b0; host_motor = 8'd0; clear_errors = 1'b0;

    // Reset state
    cycles(3);
    check("rst_ss_n", ss_n, ALL1);
    check("rst_spi_start", spi_start, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_round_done", round_done, 0);
    check("rst_is_host", is_host_slot, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_motor_index", motor_index, 0);

    // Basic polling, mask 000101, period 2000, done 10 cycles after start
    b = log_idx.size(); lb = low_len.size(); gb = gap_len.size();
    fd0 = n_fd; st0 = n_start;
    reset = 1'b0; enable = 1'b1; motor_mask = 6'b000101; done_delay = 10;
    wait_for(4, 2200, "poll_round1_wait");
    t1 = last_hit_time;
    wait_for(4, 2200, "poll_round2_wait");
    t2 = last_hit_time;
    check("poll_round_spacing", (t2 - t1) / 10, 2000);
    check("poll_frame_done_count", n_fd - fd0, 4);
    check("poll_start_count", n_start - st0, 4);
    check("poll_idx0", log_idx[b], 0);
    check("poll_idx1", log_idx[b+1], 2);
    check("poll_idx2", log_idx[b+2], 0);
    check("poll_idx3", log_idx[b+3], 2);
    for (int i = 0; i < 4; i++) check($sformatf("poll_low_len_%0d", i), low_len[lb+i], 19);
    check("poll_gap_a", gap_len[gb+1], 2);
    check("poll_gap_b", gap_len[gb+3], 2);

    // Host priority during motor 0's frame
    enable = 1'b0; motor_mask = 6'b111111; update_period = 32'd300;
    cycles(2);
    b = log_idx.size(); fd0 = n_fd; ha0 = n_hack;
    enable = 1'b1;
    wait_for(0, 400, "host_first_frame_wait");
    host_req = 1'b1; host_motor = 8'd3;
    wait_for(2, 200, "host_ack_wait");
    host_req = 1'b0;
    wait_for(4, 400, "host_round_wait");
    for (int i = 0; i < 7; i++) begin
      check($sformatf("host_order_idx_%0d", i), log_idx[b+i], exp_i[i]);
      check($sformatf("host_order_flag_%0d", i), log_host[b+i], exp_h[i]);
    end
    check("host_frame_done_count", n_fd - fd0, 6);
    check("host_ack_count", n_hack - ha0, 1);

    // Timeout: spi_done never arrives
    enable = 1'b0; motor_mask = 6'b000011; update_period = 32'd3000; done_delay = 0;
    cycles(2);
    fd0 = n_fd;
    enable = 1'b1;
    wait_for(1, 3100, "to_start_wait");
    t1 = last_hit_time;
    wait_for(3, 1100, "to_flag_wait");
    t2 = last_hit_time;
    check("to_latency", (t2 - t1) / 10, 1024);
    check("to_ss_released", ss_n, ALL1);
    check("to_no_frame_done", n_fd - fd0, 0);
    wait_for(0, 50, "to_next_select_wait");
    check("to_next_motor", motor_index, 1);
    clear_errors = 1'b1;
    cycles(1);
    clear_errors = 1'b0;
    check("to_cleared", timeout_err, 0);

    // Reset while motor 1 sits in WAIT
    cycles(100);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("rstw_ss_n", ss_n, ALL1);
    check("rstw_spi_start", spi_start, 0);
    check("rstw_motor_index", motor_index, 0);
    check("rstw_is_host", is_host_slot, 0);
    check("rstw_timeout", timeout_err, 0);
    st0 = n_start;
    cycles(200);
    check("rstw_no_start", n_start - st0, 0);
    check("rstw_ss_idle", ss_n, ALL1);

    // Overrun: period 20, frames of ~41 cycles
    enable = 1'b0;
    cycles(2);
    motor_mask = 6'b000001; update_period = 32'd20; done_delay = 30;
    enable = 1'b1;
    wait_for(1, 100, "ovr_start_wait");
    check("ovr_before", overrun, 0);
    cycles(40);
    check("ovr_set", overrun, 1);
    wait_for(4, 100, "ovr_round_a");
    t1 = last_hit_time;
    wait_for(4, 100, "ovr_round_b");
    t2 = last_hit_time;
    check("ovr_round_spacing", (t2 - t1) / 10, 60);
    enable = 1'b0;
    cycles(60);
    clear_errors = 1'b1;
    cycles(1);
    clear_errors = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Host target out of range
    b = log_idx.size(); st0 = n_start;
    host_req = 1'b1; host_motor = 8'd7;
    cycles(1);
    check("bad_host_ack", host_ack, 1);
    host_req = 1'b0;
    cycles(1);
    check("bad_host_ack_end", host_ack, 0);
    check("bad_host_ss", ss_n, ALL1);
    check("bad_host_no_frame", log_idx.size() - b, 0);
    check("bad_host_no_start", n_start - st0, 0);

    // Motor power absent blocks both polled and host frames
    b = log_idx.size(); st0 = n_start;
    power_sense_n = 1'b1; motor_mask = 6'b000001; update_period = 32'd20;
    done_delay = 5; host_req = 1'b1; host_motor = 8'd2; enable = 1'b1;
    cycles(100);
    check("pwr_no_frame", log_idx.size() - b, 0);
    check("pwr_no_start", n_start - st0, 0);
    check("pwr_ss_idle", ss_n, ALL1);
    power_sense_n = 1'b0;
    wait_for(2, 100, "pwr_host_ack_wait");
    host_req = 1'b0;
    check("pwr_host_idx", log_idx[b], 2);
    check("pwr_host_flag", log_host[b], 1);
    wait_for(4, 200, "pwr_round_wait");
    check("pwr_poll_idx", log_idx[b+1], 0);
    check("pwr_poll_flag", log_host[b+1], 0);

    check("onehot_violations", onehot_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
